// File: rtl/clock_div_pkg.sv
// Shared constants, types and helpers for the clock divider bank.
package clock_div_pkg;

  localparam int CLKDIV_CNT_W       = 25;
  localparam int CLKDIV_DEFAULT_DIV = 10_000_000;  // 2.4 Hz at 48 MHz

  typedef logic [CLKDIV_CNT_W-1:0] cnt_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: half-period counter, shadowed divisor, toggle and tick.
// The CLKDIV_SYNC_EN macro adds a sync input that restarts the channel.
module clock_div_chan import clock_div_pkg::*; #(
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt, div_cur, shadow;
  logic             term, apply;

  // >= rather than == so a divisor shrunk while idle cannot strand cnt above it.
  assign term  = (cnt >= div_cur - CNT_W'(1));
  assign apply = pending && (!en || term);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      div_cur <= DIV_RST;
      shadow  <= DIV_RST;
    end
`ifdef CLKDIV_SYNC_EN
    else if (sync) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      if (pending) begin
        div_cur <= shadow;
        pending <= 1'b0;
      end
    end
`endif
    else begin
      tick <= 1'b0;
      if (en) begin
        if (term) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (apply) begin
        div_cur <= shadow;
        pending <= 1'b0;
      end
      // A write landing on the apply edge re-arms pending with the new value.
      if (wr) begin
        shadow  <= wr_val;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_div_bank.sv
// Bank of NUM_CH programmable 50%-duty clock dividers with shadowed divisors.
// Define CLKDIV_SYNC_EN to add the sync port that phase-aligns all channels.
module clock_div_bank import clock_div_pkg::*; #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic                      int_osc,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         en,
  input  logic                      div_wr,
  input  logic [sel_w(NUM_CH)-1:0]  div_sel,
  input  logic [CNT_W-1:0]          div_val,
`ifdef CLKDIV_SYNC_EN
  input  logic                      sync,
`endif
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         pending,
  output logic                      wr_err
);

  logic              wr_ok;
  logic [NUM_CH-1:0] wr_ch;

  assign wr_ok = div_wr && (div_val != '0) && (32'(div_sel) < 32'(NUM_CH));

  always_ff @(posedge int_osc) begin
    if (reset) wr_err <= 1'b0;
    else       wr_err <= div_wr && !wr_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_ch[i] = wr_ok && (32'(div_sel) == 32'(i));

    clock_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (int_osc),
      .reset   (reset),
      .en      (en[i]),
      .wr      (wr_ch[i]),
      .wr_val  (div_val),
`ifdef CLKDIV_SYNC_EN
      .sync    (sync),
`endif
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_clock_div_bank.sv
// Directed bench for clock_div_bank (NUM_CH=2, CNT_W=8, DEFAULT_DIV=4) plus a 1-channel copy.
// Sync checks are built only when CLKDIV_SYNC_EN is defined.
module tb_clock_div_bank;

  localparam int CNT_W = 8;

  logic             int_osc = 1'b0;
  logic             reset;
  logic [1:0]       en;
  logic [0:0]       en1;
  logic             div_wr;
  logic [0:0]       div_sel;
  logic [CNT_W-1:0] div_val;
  logic             sync;
  logic [1:0]       clk_out, tick, pending;
  logic             wr_err;
  logic [0:0]       clk_out1, tick1, pending1;
  logic             wr_err1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 int_osc = ~int_osc;

  clock_div_bank #(.NUM_CH(2), .CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .int_osc (int_osc),
    .reset   (reset),
    .en      (en),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_val (div_val),
`ifdef CLKDIV_SYNC_EN
    .sync    (sync),
`endif
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending),
    .wr_err  (wr_err)
  );

  // Single-channel copy: div_sel=1 is out of range here.
  clock_div_bank #(.NUM_CH(1), .CNT_W(CNT_W), .DEFAULT_DIV(4)) dut1 (
    .int_osc (int_osc),
    .reset   (reset),
    .en      (en1),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_val (div_val),
`ifdef CLKDIV_SYNC_EN
    .sync    (sync),
`endif
    .clk_out (clk_out1),
    .tick    (tick1),
    .pending (pending1),
    .wr_err  (wr_err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge int_osc);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 2'b00; en1 = 1'b0; div_wr = 1'b0;
    div_sel = 1'b0; div_val = '0; sync = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [0:0] sel, input logic [CNT_W-1:0] val);
    div_wr = 1'b1; div_sel = sel; div_val = val;
    step(1);
    div_wr = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst clk_out", clk_out, 2'b00);
    chk("rst tick", tick, 2'b00);
    chk("rst pending", pending, 2'b00);
    chk("rst wr_err", wr_err, 1'b0);
    chk("rst wr_err1", wr_err1, 1'b0);

    // Default divisor 4: toggles at edges 4, 8, 12, 16, 20
    en = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk($sformatf("dflt clk e%0d", k), clk_out, ((k / 4) % 2 == 1) ? 2'b11 : 2'b00);
      chk($sformatf("dflt tick e%0d", k), tick, (k % 4 == 0) ? 2'b11 : 2'b00);
    end

    // ch0 divisor 2 written at edge 1, applied at the edge-4 wrap
    do_reset();
    en = 2'b11;
    wr(1'b0, 8'd2);
    chk("wr0 pending e1", pending, 2'b01);
    step(2);
    chk("wr0 pending e3", pending, 2'b01);
    chk("wr0 clk e3", clk_out, 2'b00);
    step(1);
    chk("wr0 pending e4", pending, 2'b00);
    chk("wr0 clk e4", clk_out, 2'b11);
    chk("wr0 tick e4", tick, 2'b11);
    step(1);
    chk("wr0 tick e5", tick, 2'b00);
    step(1);
    chk("wr0 clk e6", clk_out, 2'b10);
    chk("wr0 tick e6", tick, 2'b01);
    step(2);
    chk("wr0 clk e8", clk_out, 2'b01);
    chk("wr0 tick e8", tick, 2'b11);
    step(2);
    chk("wr0 clk e10", clk_out, 2'b00);

    // ch1: 3 then 5 before the wrap, only 5 applies
    do_reset();
    en = 2'b11;
    wr(1'b1, 8'd3);
    chk("lww pending e1", pending, 2'b10);
    wr(1'b1, 8'd5);
    chk("lww pending e2", pending, 2'b10);
    step(2);
    chk("lww pending e4", pending, 2'b00);
    chk("lww clk1 e4", clk_out[1], 1'b1);
    step(3);
    chk("lww clk1 e7", clk_out[1], 1'b1);
    chk("lww tick1 e7", tick[1], 1'b0);
    step(2);
    chk("lww clk1 e9", clk_out[1], 1'b0);
    chk("lww tick1 e9", tick[1], 1'b1);
    step(5);
    chk("lww clk1 e14", clk_out[1], 1'b1);
    chk("lww tick1 e14", tick[1], 1'b1);

    // Rejected writes: zero divisor, out-of-range select on the 1-channel copy
    do_reset();
    wr(1'b0, 8'd0);
    chk("err0 wr_err", wr_err, 1'b1);
    chk("err0 wr_err1", wr_err1, 1'b1);
    chk("err0 pending", pending, 2'b00);
    chk("err0 pending1", pending1, 1'b0);
    step(1);
    chk("err0 wr_err clr", wr_err, 1'b0);
    chk("err0 wr_err1 clr", wr_err1, 1'b0);
    wr(1'b1, 8'd3);
    chk("errsel wr_err", wr_err, 1'b0);
    chk("errsel pending", pending, 2'b10);
    chk("errsel wr_err1", wr_err1, 1'b1);
    chk("errsel pending1", pending1, 1'b0);
    step(1);
    chk("errsel wr_err1 clr", wr_err1, 1'b0);
    chk("errsel idle apply", pending, 2'b00);
    // ch0 shadow untouched by the zero write: still half-period 4
    en = 2'b01; en1 = 1'b1;
    step(3);
    chk("err0 shadow e3", clk_out[0], 1'b0);
    chk("err1 shadow e3", clk_out1, 1'b0);
    step(1);
    chk("err0 shadow e4", clk_out[0], 1'b1);
    chk("err1 shadow e4", clk_out1, 1'b1);

    // en[0] dropped at cnt=2 for 6 cycles
    do_reset();
    en = 2'b11;
    step(2);
    en = 2'b10;
    for (int k = 3; k <= 8; k++) begin
      step(1);
      chk($sformatf("hold clk0 e%0d", k), clk_out[0], 1'b0);
      chk($sformatf("hold tick0 e%0d", k), tick[0], 1'b0);
    end
    chk("hold clk1 e8", clk_out[1], 1'b0);
    en = 2'b11;
    step(1);
    chk("resume clk0 +1", clk_out[0], 1'b0);
    step(1);
    chk("resume clk0 +2", clk_out[0], 1'b1);
    chk("resume tick0 +2", tick[0], 1'b1);

    // N=1 applied while idle, then int_osc/2 with tick held high
    do_reset();
    wr(1'b0, 8'd1);
    chk("n1 pending e1", pending, 2'b01);
    step(1);
    chk("n1 pending e2", pending, 2'b00);
    en = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk($sformatf("n1 clk e%0d", k), clk_out[0], (k % 2 == 1) ? 1'b1 : 1'b0);
      chk($sformatf("n1 tick e%0d", k), tick[0], 1'b1);
    end

`ifdef CLKDIV_SYNC_EN
    // ch0 div 3, ch1 div 5, sync mid-period
    do_reset();
    wr(1'b0, 8'd3);
    wr(1'b1, 8'd5);
    step(1);
    chk("sync pending", pending, 2'b00);
    en = 2'b11;
    step(5);
    chk("sync pre clk", clk_out, 2'b11);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    chk("sync clk", clk_out, 2'b00);
    chk("sync tick", tick, 2'b00);
    step(2);
    chk("sync clk +2", clk_out, 2'b00);
    step(1);
    chk("sync clk +3", clk_out, 2'b01);
    chk("sync tick +3", tick, 2'b01);
    step(1);
    chk("sync clk +4", clk_out, 2'b01);
    step(1);
    chk("sync clk +5", clk_out, 2'b11);
    chk("sync tick +5", tick, 2'b10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_div_bank.md
# clock_div_bank

Bank of NUM_CH independent, runtime-programmable clock dividers driven from the on-chip oscillator, the parametrised successor to the fixed 2.4 Hz LED divider. Each channel produces a 50 %-duty square wave plus a one-cycle tick at every toggle. Divisors are loaded through a write port and applied glitch-free at the channel's next wrap. Sits between the oscillator and LED and scan-timing logic.

## Interface
- NUM_CH, 4, number of divider channels (≥1)
- CNT_W, 25, counter and divisor width
- DEFAULT_DIV, 10_000_000, reset half-period in int_osc cycles (2.4 Hz at 48 MHz)
- int_osc  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  NUM_CH  per-channel run enable
- div_wr  in  1  divisor write strobe, single cycle
- div_sel  in  SEL_W = max(1, $clog2(NUM_CH))  target channel
- div_val  in  CNT_W  new half-period N, in cycles
- sync  in  1  restart all channels (present only with CLKDIV_SYNC_EN)
- clk_out  out  NUM_CH  divided square waves
- tick  out  NUM_CH  one-cycle pulse when the matching clk_out toggles
- pending  out  NUM_CH  channel has an accepted, not-yet-applied divisor
- wr_err  out  1  one-cycle pulse for a rejected write

## Operation
- Per channel: cnt, div_cur, shadow, pending, clk_out.
- Reset: cnt=0, clk_out=0, tick=0, pending=0, wr_err=0, div_cur=shadow=DEFAULT_DIV.
- en=1: cnt increments. At cnt==div_cur-1: cnt←0, clk_out toggles, tick=1. If pending, div_cur←shadow and pending←0 at the same edge.
- en=0: cnt and clk_out hold and tick=0. A pending divisor is applied immediately, because the channel is idle.
- Write (div_wr=1, div_val≠0, div_sel<NUM_CH): shadow[div_sel]←div_val and pending←1. A later write before the apply overwrites shadow; last write wins.
- Rejected write (div_val==0, or div_sel≥NUM_CH): no state change, and wr_err pulses.
- Write in the same cycle as that channel's terminal count: the wrap applies the old shadow if pending was already set. The new value then sits in shadow with pending=1.
- N=1: clk_out toggles every cycle (int_osc/2), and tick is continuously high.
- Output frequency is f_int_osc/(2N).
- Priority, highest first: reset, then sync, then normal counting/write.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- tick and clk_out change on the same edge.
- After reset is released with en=1 held, the first clk_out rise occurs N edges later.
- A write is visible on pending one edge later. wr_err asserts one edge after the bad strobe, for exactly one cycle.
- Deasserting en freezes the phase. Reasserting it resumes from the held cnt.

## Configuration
- CLKDIV_SYNC_EN defined: the sync port exists. When sync=1, every channel takes cnt←0, clk_out←0 and tick←0, and any pending divisor is applied immediately, regardless of en. This phase-aligns all channels.
- Undefined: no sync port and no related logic. Channels are aligned only by reset.

## Structure
- Package clock_div_pkg holds:
  - CNT_W and DEFAULT_DIV default constants
  - typedef cnt_t (logic [CNT_W-1:0])
  - helper for SEL_W
- Sub-module clock_div_chan implements one channel: counter, shadow/pending, toggle, tick. The top generates NUM_CH instances and decodes writes and errors.

## Test plan
Bench parameters: NUM_CH=2, CNT_W=8, DEFAULT_DIV=4.
- Reset, then en=2'b11 for 20 cycles: clk_out rises at cycle 4, falls at cycle 8, period 8. tick pulses at 4, 8, 12, 16.
- Write ch0 div_val=2 at cycle 1: pending[0]=1 until cycle 4. From cycle 4 on, ch0 period is 4, and ch1 is unchanged.
- Write ch1 div_val=3, then div_val=5 before its wrap: only 5 is applied, and the half-period is 5 from the next wrap.
- Write div_val=0, then div_sel=1 with NUM_CH=1: wr_err is a single pulse each time, and shadow and pending are unchanged.
- en[0] dropped at cnt=2 for 6 cycles: clk_out[0] and cnt hold and tick[0]=0. Toggling resumes 2 cycles after en returns.
- With CLKDIV_SYNC_EN, ch0 div 3 and ch1 div 5: a sync pulse mid-period zeroes both outputs. Both then toggle first at 3 and 5 cycles respectively after the sync.
